// File: rtl/tree_client_if.sv
// Job intake, arbiter-leaf handshake and status signals of tree_client.
// master: upstream/arbiter side; slave: tree_client itself.
interface tree_client_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LENW  = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            job_valid;
  logic [LENW-1:0] job_len;
  logic            job_ready;
  logic [1:0]      ur;
  logic            ua;
  logic            done;
  logic            busy;
  logic [CW-1:0]   count;
  logic            err;

  modport master (
    output job_valid, job_len, ua,
    input  job_ready, ur, done, busy, count, err
  );

  modport slave (
    input  job_valid, job_len, ua,
    output job_ready, ur, done, busy, count, err
  );
endinterface

// File: rtl/tree_client.sv
// tree_client: queues jobs in a small FIFO and, per job, requests the arbiter
// leaf, holds the lock for max(job_len,1) cycles, then releases for one cycle.
module tree_client #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LENW  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tree_client_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    LOCK    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [LENW-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [LENW-1:0] hold;
  logic [LENW-1:0] head_len;
  logic            err;
  logic            job_ready;
  logic            push;
  logic            pop;

  // FIFO handshake; job_ready comes from the registered count only
  always_comb begin
    job_ready = (count < CW'(DEPTH));
    push      = bus.job_valid && job_ready;
    pop       = (state == REQUEST) && bus.ua;
    head_len  = mem[rptr];
  end

  // Job FIFO storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= bus.job_len;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Hold counter: loaded with max(len,1) at lock entry, counts down in LOCK, floors at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (pop) begin
      hold <= (head_len == '0) ? LENW'(1) : head_len;
    end else if ((state == LOCK) && (hold != '0)) begin
      hold <= hold - LENW'(1);
    end
  end

  // Sticky protocol error: grant seen outside REQUEST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err <= 1'b0;
    else if (bus.ua && (state != REQUEST))  err <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic; RELEASE always returns to IDLE so IDLE separates jobs
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = REQUEST;
      REQUEST: if (bus.ua) state_nx = LOCK;
      LOCK:    if (hold <= LENW'(1)) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: ur and done decode the state register directly
  always_comb begin
    bus.ur        = state;
    bus.done      = (state == RELEASE);
    bus.busy      = (state != IDLE) || (count != '0);
    bus.count     = count;
    bus.err       = err;
    bus.job_ready = job_ready;
  end
endmodule

// File: tb/tb_tree_client.sv
// Scoreboard bench for tree_client: each accepted job pushes its expected lock
// length; a monitor checks lock length, done/release alignment and idle gaps.
module tb_tree_client;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LENW  = 4;

  logic clk;
  logic rst_n;

  tree_client_if #(.DEPTH(DEPTH), .LENW(LENW)) bus();

  tree_client #(.DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_q[$];
  logic [1:0] ur_trace[$];
  int         cnt_trace[$];
  bit         grant_en = 0;
  bit         force_ua = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Arbiter leaf model: grants a pending request when enabled; force_ua injects stray grants
  initial begin
    bus.ua = 0;
    forever begin
      @(negedge clk);
      bus.ua = (grant_en && (bus.ur == 2'd1)) || force_ua;
    end
  end

  // Monitor / scoreboard
  initial begin
    int         lock_cnt;
    logic [1:0] prev_ur;
    lock_cnt = 0;
    prev_ur  = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lock_cnt = 0;
        prev_ur  = 2'd0;
      end else begin
        ur_trace.push_back(bus.ur);
        cnt_trace.push_back(int'(bus.count));
        if (prev_ur == 2'd3) chk("idle_after_release", bus.ur, 0);
        if (bus.ur == 2'd2) lock_cnt++;
        chk("done_vs_release", bus.done, (bus.ur == 2'd3));
        if (bus.done) begin
          chk("job_pending_at_done", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("lock_cycles", lock_cnt, exp_q.pop_front());
          lock_cnt = 0;
        end
        prev_ur = bus.ur;
      end
    end
  end

  task automatic push_job(input int len, input bit acc);
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_len   = LENW'(len);
    chk("job_ready", bus.job_ready, acc);
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    if (acc) exp_q.push_back((len == 0) ? 1 : len);
  endtask

  task automatic clr_trace();
    ur_trace.delete();
    cnt_trace.delete();
  endtask

  task automatic chk_trace(input string name, input string e_ur, input string e_cnt);
    for (int i = 0; i < e_ur.len(); i++) begin
      if (i >= ur_trace.size()) begin
        chk({name, "_trace_len"}, ur_trace.size(), e_ur.len());
        break;
      end
      chk($sformatf("%s_ur[%0d]", name, i), ur_trace[i], int'(e_ur[i]) - 48);
      if (i < e_cnt.len())
        chk($sformatf("%s_cnt[%0d]", name, i), cnt_trace[i], int'(e_cnt[i]) - 48);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;

    // Reset state
    #12;
    chk("rst_ur", bus.ur, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ur", bus.ur, 0);

    // Single job, length 3
    grant_en = 1;
    push_job(3, 1);
    clr_trace();
    repeat (8) @(negedge clk);
    chk_trace("single", "0122230", "1100000");
    wait_drain("single");

    // Zero length behaves as one lock cycle
    push_job(0, 1);
    clr_trace();
    repeat (6) @(negedge clk);
    chk_trace("zero", "01230", "11000");
    wait_drain("zero");

    // Full FIFO with grant withheld; pointers wrap during this run
    grant_en = 0;
    push_job(2, 1);
    push_job(1, 1);
    push_job(3, 1);
    push_job(1, 1);
    @(negedge clk);
    chk("full_count", bus.count, 4);
    chk("full_job_ready", bus.job_ready, 0);
    chk("full_ur", bus.ur, 1);
    chk("full_busy", bus.busy, 1);
    push_job(5, 0);
    grant_en = 1;
    @(negedge clk);
    chk("full_reject_count", bus.count, 4);
    @(negedge clk);
    chk("full_pop_count", bus.count, 3);
    chk("full_pop_job_ready", bus.job_ready, 1);
    chk("full_pop_ur", bus.ur, 2);
    wait_drain("full");

    // Back-to-back jobs
    push_job(1, 1);
    push_job(2, 1);
    clr_trace();
    repeat (10) @(negedge clk);
    chk_trace("b2b", "123012230", "211110000");
    wait_drain("b2b");

    // Push coincident with pop at lock entry
    grant_en = 0;
    push_job(2, 1);
    @(posedge clk);
    #1 grant_en = 1;
    push_job(3, 1);
    @(negedge clk);
    chk("simul_count", bus.count, 1);
    chk("simul_ur", bus.ur, 2);
    wait_drain("simul");
    chk("no_err_so_far", bus.err, 0);

    // Stray grant while IDLE
    grant_en = 0;
    @(posedge clk);
    #1 force_ua = 1;
    @(posedge clk);
    #1 force_ua = 0;
    @(negedge clk);
    chk("stray_ur", bus.ur, 0);
    chk("stray_err", bus.err, 1);
    chk("stray_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    chk("stray_err_sticky", bus.err, 1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared_by_rst", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-LOCK with jobs queued
    push_job(4, 1);
    push_job(4, 1);
    push_job(4, 1);
    @(posedge clk);
    #1 grant_en = 1;
    begin
      int n;
      n = 0;
      while ((bus.ur != 2'd2) && (n < 20)) begin
        @(negedge clk);
        n++;
      end
    end
    chk("arst_reach_lock", bus.ur, 2);
    chk("arst_queued", bus.count, 2);
    #2;
    grant_en = 0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_ur", bus.ur, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_job_ready", bus.job_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_after_ur", bus.ur, 0);
    chk("arst_after_count", bus.count, 0);
    chk("arst_after_busy", bus.busy, 0);

    // Recovery after reset
    grant_en = 1;
    push_job(1, 1);
    wait_drain("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tree_client.md
TREE_CLIENT -- requirements
Module: tree_client

Interface
REQ-001 SHALL have parameter DEPTH, default 4: job FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter LENW, default 4: width of job hold-length field.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state SHALL use this clock and reset.
REQ-004 Port list:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- job_valid  input  1  upstream offers a job.
- job_len  input  LENW  cycles the job holds the token; 0 treated as 1.
- job_ready  output  1  FIFO can accept a job.
- ur  output  2  handshake to arbiter leaf: 0=idle, 1=request, 2=lock, 3=release.
- ua  input  1  grant from arbiter leaf, active high.
- done  output  1  one-cycle pulse, job finished.
- busy  output  1  FSM not in IDLE or FIFO non-empty.
- count  output  $clog2(DEPTH)+1  jobs currently queued.
- err  output  1  sticky protocol-error flag.

Function
REQ-005 Push SHALL occur when job_valid && job_ready at a rising edge; job_len SHALL be stored at the tail.
REQ-006 job_ready SHALL be (count < DEPTH), derived from registered count only.
REQ-007 Pop SHALL occur only on the REQUEST->LOCK transition; the head job_len SHALL be loaded into the hold counter.
REQ-008 Simultaneous push and pop SHALL leave count unchanged and store the new job correctly.
REQ-009 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-010 FSM states and ur encoding: IDLE(ur=0), REQUEST(ur=1), LOCK(ur=2), RELEASE(ur=3); ur SHALL be a registered function of state only.
REQ-011 IDLE -> REQUEST when count>0; otherwise IDLE SHALL be held.
REQ-012 REQUEST SHALL be held until ua==1 is sampled, then -> LOCK; REQUEST SHALL have no timeout.
REQ-013 LOCK SHALL last exactly max(job_len,1) cycles, after which -> RELEASE.
REQ-014 RELEASE SHALL last exactly one cycle, then -> IDLE; done SHALL be 1 during that cycle only.
REQ-015 IDLE SHALL last at least one cycle between consecutive jobs, so ur never goes release->request directly.
REQ-016 ua sampled high in any state other than REQUEST SHALL be ignored by the FSM and SHALL set err.
REQ-017 err SHALL stay set until reset.
REQ-018 busy SHALL be (state!=IDLE) || (count!=0).
REQ-019 Hold counter SHALL be LENW bits wide and SHALL never underflow.

Reset
REQ-020 While rst_n==0, without waiting for clk: state=IDLE, ur=0, done=0, err=0, count=0, pointers=0, hold counter=0, job_ready=1, busy=0.
REQ-021 Reset asserted mid-job (REQUEST or LOCK) SHALL discard the current and queued jobs; no done pulse SHALL be issued.
REQ-022 After rst_n deasserts, the first state change SHALL occur at a rising clk edge.

Verification
REQ-023 Single job: push job_len=3, ua=1 held -> ur 0,1,2,2,2,3,0; done high exactly in the ur=3 cycle; count 1->0 at lock entry.
REQ-024 Zero length: push job_len=0 -> exactly one LOCK cycle, then RELEASE, then done.
REQ-025 Full FIFO: push 4 jobs, keep ua=0 -> count=4, job_ready=0, ur stays 1, and a 5th job_valid is not accepted; then ua=1 -> count drops to 3 at lock entry and job_ready=1.
REQ-026 Back-to-back jobs: queue lens 1,2 with ua=1 -> ur 1,2,3,0,1,2,2,3,0 and two done pulses.
REQ-027 Protocol error: pulse ua=1 while state=IDLE -> state unchanged and err=1 until reset.
REQ-028 Async reset: drop rst_n mid-LOCK with 2 jobs queued -> ur=0, count=0, busy=0 immediately; no done pulse.
